// File: rtl/datapath_pkg.sv
// Shared definitions for the multi-cycle datapath: ALU op codes, multiplier
// FSM states and flag-register bit positions.
package datapath_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_INC   = 4'd2;
  localparam logic [3:0] OP_DEC   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_PASSB = 4'd8;
  localparam logic [3:0] OP_SHL   = 4'd9;
  localparam logic [3:0] OP_SHR   = 4'd10;
  localparam logic [3:0] OP_SAR   = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_WB
  } mul_state_e;

  localparam int FLAG_Z    = 0;
  localparam int FLAG_N    = 1;
  localparam int FLAG_C    = 2;
  localparam int FLAG_V    = 3;
  localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/datapath_mc_seq_multiplier.sv
// Sequential shift-add multiplier: one partial-product step per cycle, then a
// single write-back cycle before returning to idle with a DONE pulse.
module seq_multiplier
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               wb_valid,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mul_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     add_sum;

  // The multiplier starts in the low half of prod; each step conditionally adds
  // the multiplicand into the high half and shifts the whole register right.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    add_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
            + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MUL;
          cnt_d   = '0;
          mcand_d = a_in;
          prod_d  = {{WIDTH{1'b0}}, b_in};
        end
      end
      S_MUL: begin
        prod_d = {add_sum, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign wb_valid = (state_q == S_WB);
  assign done     = done_q;
  assign product  = prod_q;

endmodule

// File: rtl/datapath_mc.sv
// Multi-cycle datapath: register file, ALU with registered flags, constant and
// load muxes, and a sequential multiplier that stalls issue while busy.
module datapath_mc
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int REGS  = 16,
  parameter int SEL_W = $clog2(REGS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [SEL_W-1:0] A_SEL,
  input  logic [SEL_W-1:0] B_SEL,
  input  logic [SEL_W-1:0] DEST_SEL,
  input  logic [3:0]       OP_SEL,
  input  logic [WIDTH-1:0] CONST_IN,
  input  logic             CONST_SEL,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             DATA_SEL,
  input  logic             LOAD_EN,
  output logic [WIDTH-1:0] A_OUT,
  output logic [WIDTH-1:0] B_OUT,
  output logic [WIDTH-1:0] AROUND,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             BUSY,
  output logic             DONE
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0]     regs_q [REGS];
  logic [WIDTH-1:0]     regs_d [REGS];
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [SEL_W-1:0]     mul_dest_q, mul_dest_d;

  logic [WIDTH-1:0]     a_op, b_op, add_opnd;
  logic [WIDTH:0]       sum_ext, diff_ext;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_v;
  logic                 issue_ok, mul_start;
  logic                 mul_busy, mul_wb, mul_done;
  logic [2*WIDTH-1:0]   mul_product;
  logic [WIDTH-1:0]     mul_lo, mul_hi;

  assign a_op   = regs_q[A_SEL];
  assign b_op   = CONST_SEL ? CONST_IN : regs_q[B_SEL];
  assign A_OUT  = a_op;
  assign B_OUT  = regs_q[B_SEL];
  assign AROUND = b_op;

  // Inc/dec share the add/sub adders with a constant-one operand so that carry
  // and overflow come out of the same logic as the two-operand forms.
  always_comb begin
    add_opnd = (OP_SEL == OP_INC || OP_SEL == OP_DEC) ? WIDTH'(1) : b_op;
    sum_ext  = {1'b0, a_op} + {1'b0, add_opnd};
    diff_ext = {1'b0, a_op} - {1'b0, add_opnd};
    alu_res  = a_op;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (OP_SEL)
      OP_ADD, OP_INC: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a_op[MSB] == add_opnd[MSB]) && (alu_res[MSB] != a_op[MSB]);
      end
      OP_SUB, OP_DEC: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = ~diff_ext[WIDTH];
        alu_v   = (a_op[MSB] != add_opnd[MSB]) && (alu_res[MSB] != a_op[MSB]);
      end
      OP_AND:   alu_res = a_op & b_op;
      OP_OR:    alu_res = a_op | b_op;
      OP_XOR:   alu_res = a_op ^ b_op;
      OP_NOT:   alu_res = ~a_op;
      OP_PASSB: alu_res = b_op;
      OP_SHL: begin
        alu_res = {a_op[WIDTH-2:0], 1'b0};
        alu_c   = a_op[MSB];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_op[WIDTH-1:1]};
        alu_c   = a_op[0];
      end
      OP_SAR: begin
        alu_res = {a_op[MSB], a_op[WIDTH-1:1]};
        alu_c   = a_op[0];
      end
      default: alu_res = a_op;
    endcase
  end

  assign issue_ok  = LOAD_EN && !mul_busy;
  assign mul_start = issue_ok && !DATA_SEL && (OP_SEL == OP_MUL);
  assign mul_lo    = mul_product[WIDTH-1:0];
  assign mul_hi    = mul_product[2*WIDTH-1:WIDTH];

  seq_multiplier #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk      (CLK),
    .rst      (RST),
    .start    (mul_start),
    .a_in     (a_op),
    .b_in     (b_op),
    .busy     (mul_busy),
    .wb_valid (mul_wb),
    .done     (mul_done),
    .product  (mul_product)
  );

  // Multiply write-back only occurs while busy, so it never competes with a
  // single-cycle write in the same cycle.
  always_comb begin
    regs_d     = regs_q;
    flags_d    = flags_q;
    mul_dest_d = mul_dest_q;
    if (mul_wb) begin
      regs_d[mul_dest_q] = mul_lo;
      flags_d[FLAG_Z]    = (mul_lo == '0);
      flags_d[FLAG_N]    = mul_lo[MSB];
      flags_d[FLAG_C]    = |mul_hi;
      flags_d[FLAG_V]    = 1'b0;
    end else if (issue_ok) begin
      if (DATA_SEL) begin
        regs_d[DEST_SEL] = DATA_IN;
      end else if (OP_SEL == OP_MUL) begin
        mul_dest_d = DEST_SEL;
      end else begin
        regs_d[DEST_SEL] = alu_res;
        flags_d[FLAG_Z]  = (alu_res == '0);
        flags_d[FLAG_N]  = alu_res[MSB];
        flags_d[FLAG_C]  = alu_c;
        flags_d[FLAG_V]  = alu_v;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < REGS; i++) begin
        regs_q[i] <= '0;
      end
      flags_q    <= '0;
      mul_dest_q <= '0;
    end else begin
      for (int i = 0; i < REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      flags_q    <= flags_d;
      mul_dest_q <= mul_dest_d;
    end
  end

  assign Z    = flags_q[FLAG_Z];
  assign N    = flags_q[FLAG_N];
  assign C    = flags_q[FLAG_C];
  assign V    = flags_q[FLAG_V];
  assign BUSY = mul_busy;
  assign DONE = mul_done;

endmodule

// File: tb/tb_datapath_mc.sv
// Randomised self-checking bench for datapath_mc against a cycle-level
// behavioural model built from plain integer arithmetic.
module tb_datapath_mc;

  localparam int W = 16;
  localparam int R = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [3:0]    A_SEL, B_SEL, DEST_SEL, OP_SEL;
  logic [W-1:0]  CONST_IN, DATA_IN;
  logic          CONST_SEL, DATA_SEL, LOAD_EN;
  logic [W-1:0]  A_OUT, B_OUT, AROUND;
  logic          Z, N, C, V, BUSY, DONE;

  int checks = 0;
  int failures = 0;

  int     mRegs [R];
  int     mZ, mN, mC, mV;
  int     mMulLeft, mMulDest, mDone;
  longint mMulProd;

  datapath_mc #(.WIDTH(W), .REGS(R)) dut (
    .CLK(CLK), .RST(RST), .A_SEL(A_SEL), .B_SEL(B_SEL), .DEST_SEL(DEST_SEL),
    .OP_SEL(OP_SEL), .CONST_IN(CONST_IN), .CONST_SEL(CONST_SEL),
    .DATA_IN(DATA_IN), .DATA_SEL(DATA_SEL), .LOAD_EN(LOAD_EN),
    .A_OUT(A_OUT), .B_OUT(B_OUT), .AROUND(AROUND),
    .Z(Z), .N(N), .C(C), .V(V), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int toSigned(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // Reference ALU: ordinary integer arithmetic, masked to 16 bits at the end.
  function automatic void modelAlu(input int op, input int a, input int b,
                                   output int r, output int c, output int v);
    int s;
    c = 0;
    v = 0;
    case (op)
      0:  begin r = a + b; c = (r > 65535); s = toSigned(a) + toSigned(b); v = (s > 32767 || s < -32768); end
      1:  begin r = a - b; c = (a >= b);    s = toSigned(a) - toSigned(b); v = (s > 32767 || s < -32768); end
      2:  begin r = a + 1; c = (r > 65535); s = toSigned(a) + 1;           v = (s > 32767); end
      3:  begin r = a - 1; c = (a >= 1);    s = toSigned(a) - 1;           v = (s < -32768); end
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = 65535 - a;
      8:  r = b;
      9:  begin r = a * 2; c = (a >= 32768); end
      10: begin r = a / 2; c = a % 2; end
      11: begin r = a / 2 + ((a >= 32768) ? 32768 : 0); c = a % 2; end
      default: r = a;
    endcase
    r = r & 32'hFFFF;
  endfunction

  task automatic modelEdge();
    int a, b, r, c, v;
    if (RST) begin
      foreach (mRegs[i]) mRegs[i] = 0;
      mZ = 0; mN = 0; mC = 0; mV = 0;
      mMulLeft = 0; mDone = 0;
      return;
    end
    mDone = 0;
    a = mRegs[A_SEL];
    b = CONST_SEL ? int'(CONST_IN) : mRegs[B_SEL];
    if (mMulLeft > 0) begin
      mMulLeft--;
      if (mMulLeft == 0) begin
        r = int'(mMulProd % 65536);
        mRegs[mMulDest] = r;
        mZ = (r == 0); mN = (r >= 32768); mC = ((mMulProd / 65536) != 0); mV = 0;
        mDone = 1;
      end
    end else if (LOAD_EN) begin
      if (DATA_SEL) begin
        mRegs[DEST_SEL] = int'(DATA_IN);
      end else if (OP_SEL == 4'd12) begin
        mMulLeft = W + 1;
        mMulProd = longint'(a) * longint'(b);
        mMulDest = int'(DEST_SEL);
      end else begin
        modelAlu(int'(OP_SEL), a, b, r, c, v);
        mRegs[DEST_SEL] = r;
        mZ = (r == 0); mN = (r >= 32768); mC = c; mV = v;
      end
    end
  endtask

  // One clock cycle with the currently driven inputs, checked before and after the edge.
  task automatic step();
    int expB;
    #2;
    expB = CONST_SEL ? int'(CONST_IN) : mRegs[B_SEL];
    checkOutput("A_OUT", longint'(A_OUT), longint'(mRegs[A_SEL]));
    checkOutput("B_OUT", longint'(B_OUT), longint'(mRegs[B_SEL]));
    checkOutput("AROUND", longint'(AROUND), longint'(expB));
    @(posedge CLK);
    #1;
    modelEdge();
    checkOutput("BUSY", longint'(BUSY), longint'(mMulLeft > 0));
    checkOutput("DONE", longint'(DONE), longint'(mDone));
    checkOutput("Z", longint'(Z), longint'(mZ));
    checkOutput("N", longint'(N), longint'(mN));
    checkOutput("C", longint'(C), longint'(mC));
    checkOutput("V", longint'(V), longint'(mV));
    checkOutput("A_OUT_post", longint'(A_OUT), longint'(mRegs[A_SEL]));
  endtask

  task automatic applyStimulus(input logic le, input logic ds, input logic [3:0] op,
                               input logic [3:0] dest, input logic [3:0] as,
                               input logic [3:0] bs, input logic cs,
                               input logic [W-1:0] ci, input logic [W-1:0] di);
    LOAD_EN = le; DATA_SEL = ds; OP_SEL = op; DEST_SEL = dest;
    A_SEL = as; B_SEL = bs; CONST_SEL = cs; CONST_IN = ci; DATA_IN = di;
    step();
  endtask

  task automatic checkReg(input string tag, input logic [3:0] idx, input int expected);
    LOAD_EN = 1'b0;
    A_SEL = idx;
    #1;
    checkOutput(tag, longint'(A_OUT), longint'(expected));
    step();
  endtask

  task automatic loadReg(input logic [3:0] dest, input logic [W-1:0] value);
    applyStimulus(1'b1, 1'b1, 4'd0, dest, 4'd0, 4'd0, 1'b0, '0, value);
  endtask

  task automatic runUntilIdle(input logic pulseLoads, input logic [3:0] idleDest, output int busyCycles);
    int guard;
    busyCycles = BUSY ? 1 : 0;
    guard = 0;
    while (BUSY && guard < 40) begin
      applyStimulus(pulseLoads && guard[0], 1'b1, 4'd0, idleDest, 4'd0, 4'd0, 1'b0, '0, 16'hDEAD);
      if (BUSY) busyCycles++;
      guard++;
    end
  endtask

  initial begin
    int busyCycles;
    int sawDone;
    RST = 1'b1; LOAD_EN = 0; DATA_SEL = 0; OP_SEL = 0; DEST_SEL = 0;
    A_SEL = 0; B_SEL = 0; CONST_SEL = 0; CONST_IN = 0; DATA_IN = 0;
    repeat (2) @(posedge CLK);
    #1;
    modelEdge();
    RST = 1'b0;

    checkOutput("rstBUSY", longint'(BUSY), 0);
    checkOutput("rstDONE", longint'(DONE), 0);
    checkOutput("rstFlags", longint'({Z, N, C, V}), 0);
    for (int i = 0; i < R; i++) checkReg("rstReg", 4'(i), 0);

    loadReg(4'd1, 16'h7FFF);
    loadReg(4'd2, 16'h0001);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd3, 4'd1, 4'd2, 1'b0, '0, '0);
    checkOutput("addZNCV", longint'({Z, N, C, V}), longint'(4'b0101));
    checkReg("addR3", 4'd3, 16'h8000);

    applyStimulus(1'b1, 1'b0, 4'd1, 4'd4, 4'd2, 4'd2, 1'b0, '0, '0);
    checkOutput("subZ", longint'(Z), 1);
    checkOutput("subC", longint'(C), 1);
    loadReg(4'd5, 16'h0FFF);
    checkOutput("loadKeepsFlags", longint'({Z, N, C, V}), longint'(4'b1010));
    checkReg("subR4", 4'd4, 0);

    applyStimulus(1'b1, 1'b0, 4'd4, 4'd6, 4'd5, 4'd0, 1'b1, 16'h00F0, '0);
    checkOutput("andAROUND", longint'(AROUND), 16'h00F0);
    checkReg("andR6", 4'd6, 16'h00F0);
    loadReg(4'd7, 16'h8001);
    applyStimulus(1'b1, 1'b0, 4'd11, 4'd8, 4'd7, 4'd0, 1'b0, '0, '0);
    checkOutput("sarC", longint'(C), 1);
    checkReg("sarR8", 4'd8, 16'hC000);

    loadReg(4'd9, 16'h0123);
    loadReg(4'd10, 16'h0045);
    applyStimulus(1'b1, 1'b0, 4'd12, 4'd11, 4'd9, 4'd10, 1'b0, '0, '0);
    runUntilIdle(1'b1, 4'd9, busyCycles);
    checkOutput("mulBusyCycles", longint'(busyCycles), W + 1);
    checkOutput("mulDone", longint'(DONE), 1);
    checkOutput("mulC", longint'(C), 0);
    checkReg("mulR11", 4'd11, 16'h4E6F);
    checkOutput("doneOneCycle", longint'(DONE), 0);
    checkReg("busyLoadIgnored", 4'd9, 16'h0123);

    loadReg(4'd12, 16'hFFFF);
    applyStimulus(1'b1, 1'b0, 4'd12, 4'd14, 4'd12, 4'd12, 1'b0, '0, '0);
    runUntilIdle(1'b0, 4'd15, busyCycles);
    checkOutput("mul2C", longint'(C), 1);
    checkReg("mul2R14", 4'd14, 16'h0001);
    checkReg("mul2R15", 4'd15, 0);

    applyStimulus(1'b1, 1'b0, 4'd12, 4'd13, 4'd9, 4'd10, 1'b0, '0, '0);
    repeat (4) applyStimulus(1'b0, 1'b0, 4'd0, 4'd13, 4'd0, 4'd0, 1'b0, '0, '0);
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd13, 4'd0, 4'd0, 1'b0, '0, '0);
    RST = 1'b0;
    checkOutput("rstMidBusy", longint'(BUSY), 0);
    sawDone = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 4'd13, 4'(i), 4'd0, 1'b0, '0, '0);
      if (DONE) sawDone = 1;
    end
    checkOutput("noDoneAfterRst", longint'(sawDone), 0);
    for (int i = 0; i < R; i++) checkReg("rstMidReg", 4'(i), 0);
    loadReg(4'd1, 16'h0003);
    loadReg(4'd2, 16'h0004);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd3, 4'd1, 4'd2, 1'b0, '0, '0);
    checkReg("addAfterRst", 4'd3, 7);

    for (int i = 0; i < 600; i++) begin
      RST = ($urandom_range(0, 199) == 0);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    end
    RST = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
